// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions for the RV32I core: control-word layout, ALUOp codes, default widths.
package riscv_pipe_pkg;

   localparam int XLEN_DEF = 32;
   localparam int RA_W_DEF = 5;

   // Control word {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, ALUOp[1:0], Branch, Jump}
   localparam int CTRL_W         = 9;
   localparam int CTRL_REGWRITE  = 8;
   localparam int CTRL_MEMREAD   = 7;
   localparam int CTRL_MEMWRITE  = 6;
   localparam int CTRL_MEMTOREG  = 5;
   localparam int CTRL_ALUSRC    = 4;
   localparam int CTRL_ALUOP_HI  = 3;
   localparam int CTRL_ALUOP_LO  = 2;
   localparam int CTRL_BRANCH    = 1;
   localparam int CTRL_JUMP      = 0;

   typedef enum logic [1:0] {
      ALUOP_ADD    = 2'b00,
      ALUOP_BRANCH = 2'b01,
      ALUOP_RTYPE  = 2'b10,
      ALUOP_ITYPE  = 2'b11
   } alu_op_e;

   function automatic logic ctrl_mem_read(input logic [CTRL_W-1:0] ctrl);
      return ctrl[CTRL_MEMREAD];
   endfunction

endpackage

// File: rtl/id_ex_stage_reg_load_use_detect.sv
// Load-use hazard detector: flags an ID instruction that reads the destination of a load now in EX.
module load_use_detect #(
   parameter int RA_W = 5
) (
   input  logic            ex_valid_i,
   input  logic            ex_mem_read_i,
   input  logic [RA_W-1:0] ex_rd_i,
   input  logic [RA_W-1:0] id_rs1_i,
   input  logic [RA_W-1:0] id_rs2_i,
   input  logic            id_use_rs1_i,
   input  logic            id_use_rs2_i,
   input  logic            ex_flush_i,
   output logic            stall_o
);

   logic rs1_hit;
   logic rs2_hit;

   assign rs1_hit = id_use_rs1_i && (ex_rd_i == id_rs1_i);
   assign rs2_hit = id_use_rs2_i && (ex_rd_i == id_rs2_i);

   // A flush redirects the PC, so it must never be blocked by a wrong-path hazard.
   assign stall_o = ex_valid_i && ex_mem_read_i && (ex_rd_i != '0)
                    && (rs1_hit || rs2_hit) && !ex_flush_i;

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use bubble insertion and PC / IF-ID write enables.
// Define ID_EX_PERF_CNT_EN to add bubble_cnt_o / stall_cnt_o performance counters.
module id_ex_stage_reg
   import riscv_pipe_pkg::*;
#(
   parameter int XLEN = XLEN_DEF,
   parameter int RA_W = RA_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              hold_i,
   input  logic              ex_flush_i,
   input  logic [XLEN-1:0]   id_pc_i,
   input  logic [XLEN-1:0]   id_rs1_data_i,
   input  logic [XLEN-1:0]   id_rs2_data_i,
   input  logic [XLEN-1:0]   id_imm_i,
   input  logic [RA_W-1:0]   id_rs1_i,
   input  logic [RA_W-1:0]   id_rs2_i,
   input  logic [RA_W-1:0]   id_rd_i,
   input  logic              id_use_rs1_i,
   input  logic              id_use_rs2_i,
   input  logic [2:0]        id_funct3_i,
   input  logic              id_funct7b5_i,
   input  logic [CTRL_W-1:0] id_ctrl_i,
   output logic [XLEN-1:0]   ex_pc_o,
   output logic [XLEN-1:0]   ex_rs1_data_o,
   output logic [XLEN-1:0]   ex_rs2_data_o,
   output logic [XLEN-1:0]   ex_imm_o,
   output logic [RA_W-1:0]   ex_rs1_o,
   output logic [RA_W-1:0]   ex_rs2_o,
   output logic [RA_W-1:0]   ex_rd_o,
   output logic [2:0]        ex_funct3_o,
   output logic              ex_funct7b5_o,
   output logic [CTRL_W-1:0] ex_ctrl_o,
   output logic              ex_valid_o,
   output logic              load_use_stall_o,
   output logic              pc_write_o,
   output logic              if_id_write_o
`ifdef ID_EX_PERF_CNT_EN
   ,
   output logic [31:0]       bubble_cnt_o,
   output logic [31:0]       stall_cnt_o
`endif
);

   logic [XLEN-1:0]   pc_d, pc_q;
   logic [XLEN-1:0]   rs1_data_d, rs1_data_q;
   logic [XLEN-1:0]   rs2_data_d, rs2_data_q;
   logic [XLEN-1:0]   imm_d, imm_q;
   logic [RA_W-1:0]   rs1_d, rs1_q;
   logic [RA_W-1:0]   rs2_d, rs2_q;
   logic [RA_W-1:0]   rd_d, rd_q;
   logic [2:0]        funct3_d, funct3_q;
   logic              funct7b5_d, funct7b5_q;
   logic [CTRL_W-1:0] ctrl_d, ctrl_q;
   logic              valid_d, valid_q;

   logic stall;
   logic bubble;

   load_use_detect #(.RA_W(RA_W)) u_load_use_detect (
      .ex_valid_i    (valid_q),
      .ex_mem_read_i (ctrl_mem_read(ctrl_q)),
      .ex_rd_i       (rd_q),
      .id_rs1_i      (id_rs1_i),
      .id_rs2_i      (id_rs2_i),
      .id_use_rs1_i  (id_use_rs1_i),
      .id_use_rs2_i  (id_use_rs2_i),
      .ex_flush_i    (ex_flush_i),
      .stall_o       (stall)
   );

   assign bubble = !hold_i && (ex_flush_i || stall);

   // NOTE: every _d gets its hold value first, so no path through the if-chain can infer a latch.
   always_comb begin
      pc_d       = pc_q;
      rs1_data_d = rs1_data_q;
      rs2_data_d = rs2_data_q;
      imm_d      = imm_q;
      rs1_d      = rs1_q;
      rs2_d      = rs2_q;
      rd_d       = rd_q;
      funct3_d   = funct3_q;
      funct7b5_d = funct7b5_q;
      ctrl_d     = ctrl_q;
      valid_d    = valid_q;
      if (bubble) begin
         ctrl_d  = '0;
         valid_d = 1'b0;
         rd_d    = '0;
         rs1_d   = '0;
         rs2_d   = '0;
      end else if (!hold_i) begin
         pc_d       = id_pc_i;
         rs1_data_d = id_rs1_data_i;
         rs2_data_d = id_rs2_data_i;
         imm_d      = id_imm_i;
         rs1_d      = id_rs1_i;
         rs2_d      = id_rs2_i;
         rd_d       = id_rd_i;
         funct3_d   = id_funct3_i;
         funct7b5_d = id_funct7b5_i;
         ctrl_d     = id_ctrl_i;
         valid_d    = 1'b1;
      end
   end

   // NOTE: state uses non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q       <= '0;
         rs1_data_q <= '0;
         rs2_data_q <= '0;
         imm_q      <= '0;
         rs1_q      <= '0;
         rs2_q      <= '0;
         rd_q       <= '0;
         funct3_q   <= '0;
         funct7b5_q <= 1'b0;
         ctrl_q     <= '0;
         valid_q    <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         rs1_data_q <= rs1_data_d;
         rs2_data_q <= rs2_data_d;
         imm_q      <= imm_d;
         rs1_q      <= rs1_d;
         rs2_q      <= rs2_d;
         rd_q       <= rd_d;
         funct3_q   <= funct3_d;
         funct7b5_q <= funct7b5_d;
         ctrl_q     <= ctrl_d;
         valid_q    <= valid_d;
      end
   end

`ifdef ID_EX_PERF_CNT_EN
   logic [31:0] bubble_cnt_d, bubble_cnt_q;
   logic [31:0] stall_cnt_d, stall_cnt_q;

   always_comb begin
      bubble_cnt_d = bubble_cnt_q + {31'd0, bubble};
      stall_cnt_d  = stall_cnt_q + {31'd0, stall && !hold_i};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bubble_cnt_q <= '0;
         stall_cnt_q  <= '0;
      end else begin
         bubble_cnt_q <= bubble_cnt_d;
         stall_cnt_q  <= stall_cnt_d;
      end
   end

   assign bubble_cnt_o = bubble_cnt_q;
   assign stall_cnt_o  = stall_cnt_q;
`endif

   assign ex_pc_o          = pc_q;
   assign ex_rs1_data_o    = rs1_data_q;
   assign ex_rs2_data_o    = rs2_data_q;
   assign ex_imm_o         = imm_q;
   assign ex_rs1_o         = rs1_q;
   assign ex_rs2_o         = rs2_q;
   assign ex_rd_o          = rd_q;
   assign ex_funct3_o      = funct3_q;
   assign ex_funct7b5_o    = funct7b5_q;
   assign ex_ctrl_o        = ctrl_q;
   assign ex_valid_o       = valid_q;
   assign load_use_stall_o = stall;
   assign pc_write_o       = !stall && !hold_i;
   assign if_id_write_o    = !stall && !hold_i;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Scoreboard bench for id_ex_stage_reg: driver pushes per-cycle expectations, a negedge monitor compares.
// Counter checks are compiled in when ID_EX_PERF_CNT_EN is defined.
module tb_id_ex_stage_reg;

   logic        clk;
   logic        rst_n;
   logic        hold_i;
   logic        ex_flush_i;
   logic [31:0] id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i;
   logic [4:0]  id_rs1_i, id_rs2_i, id_rd_i;
   logic        id_use_rs1_i, id_use_rs2_i;
   logic [2:0]  id_funct3_i;
   logic        id_funct7b5_i;
   logic [8:0]  id_ctrl_i;
   logic [31:0] ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o;
   logic [4:0]  ex_rs1_o, ex_rs2_o, ex_rd_o;
   logic [2:0]  ex_funct3_o;
   logic        ex_funct7b5_o;
   logic [8:0]  ex_ctrl_o;
   logic        ex_valid_o;
   logic        load_use_stall_o, pc_write_o, if_id_write_o;
`ifdef ID_EX_PERF_CNT_EN
   logic [31:0] bubble_cnt_o, stall_cnt_o;
`endif

   id_ex_stage_reg dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .hold_i           (hold_i),
      .ex_flush_i       (ex_flush_i),
      .id_pc_i          (id_pc_i),
      .id_rs1_data_i    (id_rs1_data_i),
      .id_rs2_data_i    (id_rs2_data_i),
      .id_imm_i         (id_imm_i),
      .id_rs1_i         (id_rs1_i),
      .id_rs2_i         (id_rs2_i),
      .id_rd_i          (id_rd_i),
      .id_use_rs1_i     (id_use_rs1_i),
      .id_use_rs2_i     (id_use_rs2_i),
      .id_funct3_i      (id_funct3_i),
      .id_funct7b5_i    (id_funct7b5_i),
      .id_ctrl_i        (id_ctrl_i),
      .ex_pc_o          (ex_pc_o),
      .ex_rs1_data_o    (ex_rs1_data_o),
      .ex_rs2_data_o    (ex_rs2_data_o),
      .ex_imm_o         (ex_imm_o),
      .ex_rs1_o         (ex_rs1_o),
      .ex_rs2_o         (ex_rs2_o),
      .ex_rd_o          (ex_rd_o),
      .ex_funct3_o      (ex_funct3_o),
      .ex_funct7b5_o    (ex_funct7b5_o),
      .ex_ctrl_o        (ex_ctrl_o),
      .ex_valid_o       (ex_valid_o),
      .load_use_stall_o (load_use_stall_o),
      .pc_write_o       (pc_write_o),
      .if_id_write_o    (if_id_write_o)
`ifdef ID_EX_PERF_CNT_EN
      ,
      .bubble_cnt_o     (bubble_cnt_o),
      .stall_cnt_o      (stall_cnt_o)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Control words {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, ALUOp, Branch, Jump}
   localparam logic [8:0] C_ADD  = 9'b1_0_0_0_0_10_0_0;
   localparam logic [8:0] C_ADDI = 9'b1_0_0_0_1_11_0_0;
   localparam logic [8:0] C_LW   = 9'b1_1_0_1_1_00_0_0;
   localparam logic [8:0] C_BEQ  = 9'b0_0_0_0_0_01_1_0;

   typedef struct {
      logic       rst_n, hold, flush;
      logic [31:0] pc;
      logic [4:0] rs1, rs2, rd;
      logic       use1, use2;
      logic [8:0] ctrl;
      logic [2:0] f3;
      logic       exp_stall;
   } vec_t;

   typedef struct {
      logic        valid, data_known, stall, pcw;
      logic [8:0]  ctrl;
      logic [4:0]  rd, rs1, rs2;
      logic [31:0] pc, rs1d, rs2d, imm;
      logic [2:0]  f3;
      logic        f7;
      logic [31:0] bcnt, scnt;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   exp_t m;
   int   checks = 0;
   int   errors = 0;

   function automatic vec_t mk(logic r, logic h, logic f, logic [31:0] pc,
                               logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                               logic u1, logic u2, logic [8:0] ctrl, logic [2:0] f3,
                               logic exp_stall);
      vec_t v;
      v.rst_n = r; v.hold = h; v.flush = f; v.pc = pc;
      v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.use1 = u1; v.use2 = u2;
      v.ctrl = ctrl; v.f3 = f3; v.exp_stall = exp_stall;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input vec_t v);
      rst_n         = v.rst_n;
      hold_i        = v.hold;
      ex_flush_i    = v.flush;
      id_pc_i       = v.pc;
      id_rs1_data_i = {16'hA5A5, v.pc[15:0]};
      id_rs2_data_i = {16'h5A5A, v.pc[15:0]};
      id_imm_i      = {v.pc[15:0], 16'h0F0F};
      id_rs1_i      = v.rs1;
      id_rs2_i      = v.rs2;
      id_rd_i       = v.rd;
      id_use_rs1_i  = v.use1;
      id_use_rs2_i  = v.use2;
      id_funct3_i   = v.f3;
      id_funct7b5_i = v.pc[2];
      id_ctrl_i     = v.ctrl;
      if (!v.rst_n) begin
         id_pc_i       = $urandom;
         id_rs1_data_i = $urandom;
         id_rs2_data_i = $urandom;
         id_imm_i      = $urandom;
         id_ctrl_i     = 9'($urandom);
         id_rd_i       = 5'($urandom);
      end
      m.stall = v.exp_stall;
      m.pcw   = !v.exp_stall && !v.hold;
      sb.push_back(m);
      if (!v.rst_n) begin
         m = '{valid: 1'b0, data_known: 1'b1, stall: 1'b0, pcw: 1'b1, ctrl: '0, rd: '0,
               rs1: '0, rs2: '0, pc: '0, rs1d: '0, rs2d: '0, imm: '0, f3: '0, f7: 1'b0,
               bcnt: '0, scnt: '0};
      end else if (!v.hold) begin
         if (v.flush || v.exp_stall) begin
            m.valid = 1'b0; m.data_known = 1'b0; m.ctrl = '0;
            m.rd = '0; m.rs1 = '0; m.rs2 = '0;
            m.bcnt++;
            if (v.exp_stall) m.scnt++;
         end else begin
            m.valid = 1'b1; m.data_known = 1'b1; m.ctrl = id_ctrl_i;
            m.rd = id_rd_i; m.rs1 = id_rs1_i; m.rs2 = id_rs2_i;
            m.pc = id_pc_i; m.rs1d = id_rs1_data_i; m.rs2d = id_rs2_data_i;
            m.imm = id_imm_i; m.f3 = id_funct3_i; m.f7 = id_funct7b5_i;
         end
      end
      @(posedge clk);
      #1;
   endtask

   // Monitor: one expectation per cycle, compared mid-cycle against settled outputs.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("valid",    {31'd0, ex_valid_o},       {31'd0, e.valid});
            check("ctrl",     {23'd0, ex_ctrl_o},        {23'd0, e.ctrl});
            check("rd",       {27'd0, ex_rd_o},          {27'd0, e.rd});
            check("rs1",      {27'd0, ex_rs1_o},         {27'd0, e.rs1});
            check("rs2",      {27'd0, ex_rs2_o},         {27'd0, e.rs2});
            check("stall",    {31'd0, load_use_stall_o}, {31'd0, e.stall});
            check("pc_write", {31'd0, pc_write_o},       {31'd0, e.pcw});
            check("if_id_wr", {31'd0, if_id_write_o},    {31'd0, e.pcw});
            if (e.data_known) begin
               check("pc",      ex_pc_o,       e.pc);
               check("rs1_data", ex_rs1_data_o, e.rs1d);
               check("rs2_data", ex_rs2_data_o, e.rs2d);
               check("imm",     ex_imm_o,      e.imm);
               check("funct3",  {29'd0, ex_funct3_o},   {29'd0, e.f3});
               check("funct7b5", {31'd0, ex_funct7b5_o}, {31'd0, e.f7});
            end
`ifdef ID_EX_PERF_CNT_EN
            check("bubble_cnt", bubble_cnt_o, e.bcnt);
            check("stall_cnt",  stall_cnt_o,  e.scnt);
`endif
         end
      end
   end

   initial begin
      //             rst  hold flsh pc        rs1 rs2 rd  u1 u2 ctrl    f3    stall
      vecs.push_back(mk(0, 0, 0, 32'h00, 5'd0,  5'd0,  5'd0,  0, 0, 9'h0,   3'd0, 0)); // reset, random id_*
      vecs.push_back(mk(0, 0, 0, 32'h00, 5'd0,  5'd0,  5'd0,  0, 0, 9'h0,   3'd0, 0));
      vecs.push_back(mk(1, 0, 0, 32'h10, 5'd1,  5'd2,  5'd3,  1, 1, C_ADD,  3'd0, 0)); // add x3,x1,x2
      vecs.push_back(mk(1, 0, 0, 32'h14, 5'd1,  5'd0,  5'd5,  1, 0, C_LW,   3'd2, 0)); // lw x5
      vecs.push_back(mk(1, 0, 0, 32'h18, 5'd5,  5'd7,  5'd6,  1, 1, C_ADD,  3'd0, 1)); // add x6,x5,x7: hazard
      vecs.push_back(mk(1, 0, 0, 32'h18, 5'd5,  5'd7,  5'd6,  1, 1, C_ADD,  3'd0, 0)); // after bubble: capture
      vecs.push_back(mk(1, 0, 0, 32'h1C, 5'd2,  5'd0,  5'd0,  1, 0, C_LW,   3'd2, 0)); // lw x0
      vecs.push_back(mk(1, 0, 0, 32'h20, 5'd0,  5'd0,  5'd8,  1, 1, C_ADD,  3'd0, 0)); // add x8,x0,x0: no stall
      vecs.push_back(mk(1, 0, 0, 32'h24, 5'd1,  5'd0,  5'd9,  1, 0, C_LW,   3'd2, 0)); // lw x9
      vecs.push_back(mk(1, 0, 0, 32'h28, 5'd4,  5'd9,  5'd10, 1, 0, C_ADDI, 3'd0, 0)); // rs2=x9 unused
      vecs.push_back(mk(1, 0, 0, 32'h2C, 5'd1,  5'd0,  5'd11, 1, 0, C_LW,   3'd2, 0)); // lw x11
      vecs.push_back(mk(1, 0, 0, 32'h30, 5'd2,  5'd11, 5'd12, 1, 0, C_LW,   3'd2, 0)); // lw x12: independent
      vecs.push_back(mk(1, 0, 1, 32'h34, 5'd12, 5'd1,  5'd13, 1, 1, C_ADD,  3'd0, 0)); // hazard + flush
      vecs.push_back(mk(1, 0, 0, 32'h40, 5'd1,  5'd2,  5'd0,  1, 1, C_BEQ,  3'd0, 0)); // beq after flush bubble
      vecs.push_back(mk(1, 0, 0, 32'h44, 5'd1,  5'd0,  5'd14, 1, 0, C_LW,   3'd2, 0)); // lw x14
      vecs.push_back(mk(1, 1, 0, 32'h48, 5'd14, 5'd2,  5'd15, 1, 1, C_ADD,  3'd0, 1)); // hold + hazard
      vecs.push_back(mk(1, 1, 0, 32'h4C, 5'd3,  5'd4,  5'd16, 1, 1, C_ADD,  3'd7, 0)); // hold, no hazard
      vecs.push_back(mk(1, 1, 0, 32'h50, 5'd14, 5'd0,  5'd17, 1, 0, C_ADDI, 3'd1, 1)); // hold + hazard
      vecs.push_back(mk(1, 0, 0, 32'h48, 5'd14, 5'd2,  5'd15, 1, 1, C_ADD,  3'd0, 1)); // release: bubble
      vecs.push_back(mk(1, 0, 0, 32'h48, 5'd14, 5'd2,  5'd15, 1, 1, C_ADD,  3'd0, 0)); // capture add x15
      vecs.push_back(mk(0, 0, 0, 32'h00, 5'd0,  5'd0,  5'd0,  0, 0, 9'h0,   3'd0, 0)); // mid-run reset
      vecs.push_back(mk(1, 0, 0, 32'h00, 5'd0,  5'd0,  5'd0,  0, 0, 9'h0,   3'd0, 0)); // nop
      vecs.push_back(mk(1, 0, 0, 32'h58, 5'd1,  5'd2,  5'd3,  1, 1, C_ADD,  3'd0, 0));

      rst_n = 1'b0; hold_i = 1'b0; ex_flush_i = 1'b0;
      id_pc_i = $urandom; id_rs1_data_i = $urandom; id_rs2_data_i = $urandom; id_imm_i = $urandom;
      id_rs1_i = 5'($urandom); id_rs2_i = 5'($urandom); id_rd_i = 5'($urandom);
      id_use_rs1_i = 1'b1; id_use_rs2_i = 1'b1; id_funct3_i = 3'($urandom);
      id_funct7b5_i = 1'b1; id_ctrl_i = 9'($urandom);
      m = '{valid: 1'b0, data_known: 1'b1, stall: 1'b0, pcw: 1'b1, ctrl: '0, rd: '0,
            rs1: '0, rs2: '0, pc: '0, rs1d: '0, rs2d: '0, imm: '0, f3: '0, f7: 1'b0,
            bcnt: '0, scnt: '0};
      repeat (2) @(posedge clk);
      #1;

      foreach (vecs[i]) step(vecs[i]);

      for (int n = 0; n < 10 && sb.size() > 0; n++) @(negedge clk);
      if (sb.size() > 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", sb.size());
      end
      @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- ID/EX pipeline register of the 5-stage RV32I core, with integrated load-use hazard detection.
- Captures decoded operands, register indices and control bits from ID.
- Drives EX and supplies ID_EX_RS1/RS2 to the downstream forwarding unit.
- Inserts bubbles on load-use hazards and on branch flush, and tells IF/ID and the PC to hold.

Parameters:
- XLEN, 32, datapath width (PC, operands, immediate).
- RA_W, 5, register index width.

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset
- hold_i  in  1  global pipeline freeze (memory wait); register keeps contents
- ex_flush_i  in  1  branch/jump taken in EX; ID contents are wrong-path
- id_pc_i  in  XLEN  PC of instruction in ID
- id_rs1_data_i, id_rs2_data_i  in  XLEN  register-file read data
- id_imm_i  in  XLEN  sign-extended immediate
- id_rs1_i, id_rs2_i, id_rd_i  in  RA_W  register indices
- id_use_rs1_i, id_use_rs2_i  in  1  instruction actually reads rs1/rs2
- id_funct3_i  in  3;  id_funct7b5_i  in  1
- id_ctrl_i  in  9  {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, ALUOp[1:0], Branch, Jump}
- ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o  out  XLEN
- ex_rs1_o, ex_rs2_o, ex_rd_o  out  RA_W  (ex_rs1_o/ex_rs2_o feed ID_EX_RS1/ID_EX_RS2)
- ex_funct3_o  out  3;  ex_funct7b5_o  out  1;  ex_ctrl_o  out  9;  ex_valid_o  out  1
- load_use_stall_o  out  1  hazard detected this cycle
- pc_write_o, if_id_write_o  out  1  enables for PC and IF/ID register

Behaviour:
- All state updates on posedge clk.
- Reset: rst_n=0 at an edge clears every registered output to 0, including ex_valid_o and ex_ctrl_o.
- Hazard (combinational): load_use_stall_o = ex_valid_o & ex_ctrl_o.MemRead & (ex_rd_o!=0) & ((id_use_rs1_i & ex_rd_o==id_rs1_i) | (id_use_rs2_i & ex_rd_o==id_rs2_i)) & ~ex_flush_i.
- pc_write_o = if_id_write_o = ~load_use_stall_o & ~hold_i.
- Per-edge priority, highest first:
  1. Reset.
  2. hold_i=1: all fields retained.
  3. ex_flush_i=1: bubble.
  4. load_use_stall_o=1: bubble.
  5. Otherwise capture all id_* inputs, ex_valid_o<=1.
- Bubble: ex_ctrl_o<=0, ex_valid_o<=0, ex_rd_o<=0, ex_rs1_o<=0, ex_rs2_o<=0; data fields don't-care and hold.
- Latency: one cycle from ID to EX. A load-use stall costs exactly one bubble. The next cycle MemRead=0 in ID/EX, so the stall self-clears and the dependent instruction is then captured; the forwarding unit supplies the load data via MEM/WB.
- Flush and hazard in the same cycle: flush wins and stall is suppressed so the PC redirect is not blocked.
- Hold with hazard: register frozen; stall output still reflects the hazard.
- x0 destination never triggers a stall.
- Back-to-back loads with no dependency: no stall.

Optional Feature:
- Macro ID_EX_PERF_CNT_EN.
- Defined:
  - Adds outputs bubble_cnt_o[31:0] and stall_cnt_o[31:0].
  - stall_cnt_o increments on each edge where load_use_stall_o=1 and hold_i=0.
  - bubble_cnt_o increments on each edge that writes a bubble (flush or stall, hold_i=0).
  - Both clear on reset and wrap modulo 2^32.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package riscv_pipe_pkg holds:
  - CTRL_W=9 and ctrl bit-position constants (CTRL_REGWRITE … CTRL_JUMP).
  - ALUOp encodings.
  - XLEN/RA_W defaults.
- One sub-module, load_use_detect: combinational stall equation. It is also reusable by a future hazard unit.

Test Plan:
- Reset: rst_n=0 for 2 cycles with random id_* inputs -> all outputs 0, ex_valid_o=0, pc_write_o=1.
- Capture: add x3,x1,x2 (pc=0x10, rs1=1, rs2=2, rd=3, RegWrite=1) -> next cycle ex_rd_o=3, ex_rs1_o=1, ex_valid_o=1, ctrl matches.
- Load-use: lw x5 in ID/EX, ID add x6,x5,x7 -> load_use_stall_o=1, pc_write_o=0. Next cycle ex_ctrl_o=0, ex_valid_o=0, stall=0. Following cycle ex_rs1_o=5 captured.
- x0/no-use: lw x0, or dependent rs2 with id_use_rs2_i=0 -> no stall.
- Flush+hazard: same cycle as load-use, ex_flush_i=1 -> stall=0, pc_write_o=1, bubble written.
- Hold: hold_i=1 for 3 cycles with changing inputs -> outputs unchanged. With ID_EX_PERF_CNT_EN, counters unchanged during hold and +1 after each stall/flush bubble.
